calc_entry_ctrl: RTL and testbench

Sequential front-end that sits directly upstream of the combinational 4-bit add/subtract calculator. It accepts a keypad-style key stream, A digit, operator, B digit and equals, over a valid/ready handshake. It drives the calculator's A/B/op inputs, captures the calculator's 5-bit RESULT one cycle later, and presents it on a valid/ready output handshake. The calculator is a sibling instance wired at the parent level.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/calc_entry_ctrl.sv | 153 +++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator keypad front-end: key codes, FSM states and op encodings.
package calc_pkg;

   typedef enum logic [1:0] {
      KEY_DIGIT = 2'b00,
      KEY_ADD   = 2'b01,
      KEY_SUB   = 2'b10,
      KEY_EQ    = 2'b11
   } key_type_e;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_EQ   = 3'd3,
      S_EXEC = 3'd4,
      S_OUT  = 3'd5
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/calc_entry_ctrl.sv
// Keypad-driven front-end for the combinational add/sub calculator: collects A, op, B, EQ,
// holds registered operands for the sibling calculator and captures its result one cycle later.
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int DW    = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [1:0]       key_type,
   input  logic [DW-1:0]    key_data,
   output logic [DW-1:0]    calc_a,
   output logic [DW-1:0]    calc_b,
   output logic             calc_op,
   input  logic [DW:0]      calc_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DW:0]      res_data,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   state_e           state_q, state_d;
   logic [DW-1:0]    calc_a_q, calc_a_d;
   logic [DW-1:0]    calc_b_q, calc_b_d;
   logic             calc_op_q, calc_op_d;
   logic [DW:0]      res_data_q, res_data_d;
   logic             res_valid_q, res_valid_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   key_type_e kt;
   logic      key_fire;
   logic      entry_state;

   assign kt          = key_type_e'(key_type);
   assign entry_state = (state_q == S_A) || (state_q == S_OP) ||
                        (state_q == S_B) || (state_q == S_EQ);
   // clear masks ready so a key coincident with an abort is never consumed
   assign key_ready   = entry_state && !clear;
   assign key_fire    = key_valid && key_ready;

   always_comb begin
      state_d     = state_q;
      calc_a_d    = calc_a_q;
      calc_b_d    = calc_b_q;
      calc_op_d   = calc_op_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      op_count_d  = op_count_q;

      if (clear) begin
         state_d     = S_A;
         calc_a_d    = '0;
         calc_b_d    = '0;
         calc_op_d   = OP_ADD;
         res_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_A: begin
               if (key_fire && kt == KEY_DIGIT) begin
                  calc_a_d = key_data;
                  state_d  = S_OP;
               end
            end
            S_OP: begin
               if (key_fire) begin
                  case (kt)
                     KEY_DIGIT: calc_a_d = key_data;
                     KEY_ADD: begin
                        calc_op_d = OP_ADD;
                        state_d   = S_B;
                     end
                     KEY_SUB: begin
                        calc_op_d = OP_SUB;
                        state_d   = S_B;
                     end
                     default: ;
                  endcase
               end
            end
            S_B: begin
               if (key_fire) begin
                  case (kt)
                     KEY_DIGIT: begin
                        calc_b_d = key_data;
                        state_d  = S_EQ;
                     end
                     KEY_ADD: calc_op_d = OP_ADD;
                     KEY_SUB: calc_op_d = OP_SUB;
                     default: ;
                  endcase
               end
            end
            S_EQ: begin
               if (key_fire) begin
                  if (kt == KEY_DIGIT) calc_b_d = key_data;
                  else if (kt == KEY_EQ) state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               // operands have been registered for a full cycle, so the result has settled
               res_data_d  = calc_result;
               res_valid_d = 1'b1;
               op_count_d  = op_count_q + CNT_W'(1);
               state_d     = S_OUT;
            end
            S_OUT: begin
               if (res_ready) begin
                  res_valid_d = 1'b0;
                  calc_a_d    = '0;
                  calc_b_d    = '0;
                  calc_op_d   = OP_ADD;
                  state_d     = S_A;
               end
            end
            default: state_d = S_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_A;
         calc_a_q    <= '0;
         calc_b_q    <= '0;
         calc_op_q   <= OP_ADD;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         calc_a_q    <= calc_a_d;
         calc_b_q    <= calc_b_d;
         calc_op_q   <= calc_op_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         op_count_q  <= op_count_d;
      end
   end

   assign calc_a    = calc_a_q;
   assign calc_b    = calc_b_q;
   assign calc_op   = calc_op_q;
   assign res_data  = res_data_q;
   assign res_valid = res_valid_q;
   assign op_count  = op_count_q;
   assign busy      = (state_q == S_EXEC) || (state_q == S_OUT);

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench: calc_entry_ctrl beside a behavioural 4-bit add/sub calculator.
module tb_calc_entry_ctrl;
   import calc_pkg::*;

   localparam int DW    = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear;
   logic             key_valid;
   logic             key_ready;
   logic [1:0]       key_type;
   logic [DW-1:0]    key_data;
   logic [DW-1:0]    calc_a;
   logic [DW-1:0]    calc_b;
   logic             calc_op;
   logic [DW:0]      calc_result;
   logic             res_valid;
   logic             res_ready;
   logic [DW:0]      res_data;
   logic             busy;
   logic [CNT_W-1:0] op_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // sibling calculator: subtraction adds the two's complement of B
   assign calc_result = calc_op ? ({1'b0, calc_a} + {1'b0, ~calc_b} + 5'd1)
                                : ({1'b0, calc_a} + {1'b0, calc_b});

   calc_entry_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .key_valid(key_valid), .key_ready(key_ready), .key_type(key_type), .key_data(key_data),
      .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op), .calc_result(calc_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .op_count(op_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [1:0] t, input logic [3:0] d);
      key_valid = 1'b1;
      key_type  = t;
      key_data  = d;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic do_op(input logic [3:0] a, input logic [1:0] op, input logic [3:0] b);
      press(KEY_DIGIT, a);
      press(op, 4'd0);
      press(KEY_DIGIT, b);
      press(KEY_EQ, 4'd0);
      tick();
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; key_valid = 1'b0; key_type = 2'b00;
      key_data = '0; res_ready = 1'b1;
      tick(); tick();
      chk("rst_key_ready", key_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_calc_a", calc_a, 0);
      rst_n = 1'b1;
      tick();

      // 7 + 5, consumer ready
      press(KEY_DIGIT, 4'd7);
      chk("t1_calc_a", calc_a, 7);
      press(KEY_ADD, 0);
      press(KEY_DIGIT, 4'd5);
      press(KEY_EQ, 0);
      chk("t1_exec_busy", busy, 1);
      chk("t1_exec_key_ready", key_ready, 0);
      chk("t1_exec_res_valid", res_valid, 0);
      tick();
      chk("t1_res_valid", res_valid, 1);
      chk("t1_res_data", res_data, 5'b01100);
      chk("t1_op_count", op_count, 1);
      tick();
      chk("t1_res_valid_drop", res_valid, 0);
      chk("t1_calc_a_zero", calc_a, 0);
      chk("t1_key_ready", key_ready, 1);
      $display("op 7+5 -> res_data=%b op_count=%0d", res_data, op_count);

      // 9 - 3 with back-pressure and a pending key
      res_ready = 1'b0;
      press(KEY_DIGIT, 4'd9);
      press(KEY_SUB, 0);
      press(KEY_DIGIT, 4'd3);
      press(KEY_EQ, 0);
      tick();
      key_valid = 1'b1; key_type = KEY_DIGIT; key_data = 4'd6;
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", res_valid, 1);
         chk("t2_hold_data", res_data, 5'b10110);
         chk("t2_hold_key_ready", key_ready, 0);
         chk("t2_hold_busy", busy, 1);
         tick();
      end
      res_ready = 1'b1;
      tick();
      chk("t2_released_valid", res_valid, 0);
      chk("t2_key_not_taken", calc_a, 0);
      chk("t2_key_ready", key_ready, 1);
      tick();
      key_valid = 1'b0;
      chk("t2_key_taken", calc_a, 6);
      press(KEY_ADD, 0);
      press(KEY_DIGIT, 4'd1);
      press(KEY_EQ, 0);
      tick();
      chk("t2b_res_data", res_data, 5'b00111);
      chk("t2b_op_count", op_count, 3);
      tick();
      $display("op 9-3 held 5 cycles, then 6+1 -> res_data=%b op_count=%0d", res_data, op_count);

      // overwrites and operator replacement
      press(KEY_DIGIT, 4'd2);
      press(KEY_DIGIT, 4'd15);
      press(KEY_ADD, 0);
      press(KEY_SUB, 0);
      press(KEY_DIGIT, 4'd1);
      press(KEY_DIGIT, 4'd4);
      chk("t3_calc_a", calc_a, 15);
      chk("t3_calc_op", calc_op, 1);
      chk("t3_calc_b", calc_b, 4);
      press(KEY_EQ, 0);
      tick();
      chk("t3_res_data", res_data, 5'b11011);
      chk("t3_op_count", op_count, 4);
      tick();
      $display("op 15-4 with overwrites -> res_data=%b", res_data);

      // leading operator keys ignored in S_A
      press(KEY_EQ, 0);
      press(KEY_ADD, 0);
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_calc_a", calc_a, 0);
      press(KEY_DIGIT, 4'd15);
      press(KEY_ADD, 0);
      press(KEY_DIGIT, 4'd15);
      chk("t4_calc_op", calc_op, 0);
      press(KEY_EQ, 0);
      tick();
      chk("t4_res_data", res_data, 5'b11110);
      chk("t4_op_count", op_count, 5);
      tick();
      $display("op 15+15 after ignored keys -> res_data=%b", res_data);

      // clear during S_EXEC
      press(KEY_DIGIT, 4'd1);
      press(KEY_ADD, 0);
      press(KEY_DIGIT, 4'd1);
      press(KEY_EQ, 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5_exec_clr_valid", res_valid, 0);
      chk("t5_exec_clr_busy", busy, 0);
      chk("t5_exec_clr_count", op_count, 5);
      chk("t5_exec_clr_data", res_data, 5'b11110);
      chk("t5_exec_clr_b", calc_b, 0);
      tick();
      chk("t5_exec_clr_no_result", res_valid, 0);
      $display("clear in S_EXEC -> res_valid=%0d op_count=%0d", res_valid, op_count);

      // clear beats a simultaneous key
      clear = 1'b1; key_valid = 1'b1; key_type = KEY_DIGIT; key_data = 4'd3;
      #1;
      chk("t5_clr_key_ready", key_ready, 0);
      tick();
      clear = 1'b0; key_valid = 1'b0;
      chk("t5_clr_key_dropped", calc_a, 0);

      // clear during S_OUT with res_ready
      res_ready = 1'b0;
      press(KEY_DIGIT, 4'd2);
      press(KEY_ADD, 0);
      press(KEY_DIGIT, 4'd2);
      press(KEY_EQ, 0);
      tick();
      chk("t5_out_valid", res_valid, 1);
      chk("t5_out_count", op_count, 6);
      clear = 1'b1; res_ready = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5_out_clr_valid", res_valid, 0);
      chk("t5_out_clr_busy", busy, 0);
      chk("t5_out_clr_count", op_count, 6);
      chk("t5_out_clr_data", res_data, 5'b00100);
      $display("clear in S_OUT -> res_valid=%0d op_count=%0d", res_valid, op_count);

      // asynchronous reset while in S_B
      press(KEY_DIGIT, 4'd3);
      press(KEY_SUB, 0);
      chk("t5_sb_calc_op", calc_op, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_arst_calc_a", calc_a, 0);
      chk("t5_arst_calc_op", calc_op, 0);
      chk("t5_arst_count", op_count, 0);
      chk("t5_arst_data", res_data, 0);
      chk("t5_arst_key_ready", key_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      $display("async reset in S_B -> op_count=%0d calc_a=%0d", op_count, calc_a);

      // counter wrap
      for (int i = 0; i < 255; i++) do_op(4'd1, KEY_ADD, 4'd1);
      chk("t6_count_255", op_count, 255);
      do_op(4'd1, KEY_ADD, 4'd2);
      chk("t6_count_wrap0", op_count, 0);
      chk("t6_wrap_res", res_data, 5'b00011);
      do_op(4'd9, KEY_SUB, 4'd0);
      chk("t6_count_wrap1", op_count, 1);
      chk("t6_sub_zero_res", res_data, 5'b11001);
      $display("counter wrap -> op_count=%0d", op_count);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
